// File: rtl/sdram_wr_burst_ctrl_if.sv
// -----------------------------------------------------------------------------
// sdram_wr_burst_ctrl_if
// Bundles the pixel input stream, the SDRAM controller write port and the
// status outputs of sdram_wr_burst_ctrl into one interface.
//
// Signals
//   pix_en / pix_data / frame_start   pixel stream from the window split stage
//   sdram_wr_req / sdram_wr_addr      burst request towards the SDRAM controller
//   sdram_wr_ack / sdram_wr_dreq      controller accept pulse and word pull
//   sdram_wr_data                     pulled word, one cycle after dreq
//   frame_done / rd_bank              frame completion pulse and finished bank
//   fifo_ovf / sync_err               sticky error flags
//
// Modports
//   slave  : the burst controller itself
//   master : the surrounding system (pixel source + SDRAM controller)
// -----------------------------------------------------------------------------
interface sdram_wr_burst_ctrl_if #(
    parameter int ADDR_W = 22
) ();
    logic              pix_en;
    logic [15:0]       pix_data;
    logic              frame_start;
    logic              sdram_wr_req;
    logic [ADDR_W-1:0] sdram_wr_addr;
    logic              sdram_wr_ack;
    logic              sdram_wr_dreq;
    logic [15:0]       sdram_wr_data;
    logic              frame_done;
    logic              rd_bank;
    logic              fifo_ovf;
    logic              sync_err;

    modport slave (
        input  pix_en, pix_data, frame_start, sdram_wr_ack, sdram_wr_dreq,
        output sdram_wr_req, sdram_wr_addr, sdram_wr_data,
        output frame_done, rd_bank, fifo_ovf, sync_err
    );

    modport master (
        output pix_en, pix_data, frame_start, sdram_wr_ack, sdram_wr_dreq,
        input  sdram_wr_req, sdram_wr_addr, sdram_wr_data,
        input  frame_done, rd_bank, fifo_ovf, sync_err
    );
endinterface

// File: rtl/sdram_wr_burst_ctrl.sv
// -----------------------------------------------------------------------------
// sdram_wr_burst_ctrl
// Buffers an RGB565 pixel stream in an internal FIFO and writes it to SDRAM
// as fixed-length bursts with linear frame addressing.
//
// Ports
//   clk    system clock (single clock domain)
//   rstn   asynchronous active-low reset
//   bus    sdram_wr_burst_ctrl_if.slave: pixel input, SDRAM write port,
//          frame_done / rd_bank / fifo_ovf / sync_err status
//
// Parameters
//   BURST_LEN   words per burst, power of 2 (>= 2), <= FIFO_DEPTH/2
//   FIFO_DEPTH  buffer depth, power of 2
//   FRAME_WORDS words per frame, integer multiple of BURST_LEN
//   ADDR_W      SDRAM word address width
//   BASE_ADDR0  frame base of bank 0
//   BASE_ADDR1  frame base of bank 1 (ping-pong builds only)
//
// Build option
//   WR_PINGPONG_EN  when defined, consecutive frames alternate between bank 0
//                   and bank 1 and rd_bank reports the bank just completed.
//                   When undefined, all frames go to BASE_ADDR0 and rd_bank
//                   stays 0.
// -----------------------------------------------------------------------------
module sdram_wr_burst_ctrl #(
    parameter int                BURST_LEN   = 64,
    parameter int                FIFO_DEPTH  = 512,
    parameter int                FRAME_WORDS = 307200,
    parameter int                ADDR_W      = 22,
    parameter logic [ADDR_W-1:0] BASE_ADDR0  = 22'h000000,
    parameter logic [ADDR_W-1:0] BASE_ADDR1  = 22'h080000
) (
    input  logic                 clk,
    input  logic                 rstn,
    sdram_wr_burst_ctrl_if.slave bus
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = $clog2(BURST_LEN);

    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  BURST_CNT  = CNT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_END  = ADDR_W'(FRAME_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_XFER  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // State registers
    state_t            state_q,      state_d;
    logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0]  count_q,      count_d;
    logic [BEAT_W-1:0] beat_q,       beat_d;
    logic [ADDR_W-1:0] offset_q,     offset_d;
    logic              bank_q,       bank_d;
    logic              flush_pend_q, flush_pend_d;

    // Output registers
    logic              req_q,        req_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [15:0]       data_q,       data_d;
    logic              frame_done_q, frame_done_d;
    logic              rd_bank_q,    rd_bank_d;
    logic              ovf_q,        ovf_d;
    logic              sync_err_q,   sync_err_d;

    // Pixel buffer storage
    logic [15:0]       mem_q [FIFO_DEPTH];

    // Combinational helpers
    logic              fifo_full_s;
    logic              fifo_wr_s;
    logic              fifo_rd_s;
    logic              frame_aligned_s;
    logic [ADDR_W-1:0] next_offset_s;
    logic [ADDR_W-1:0] burst_base_s;

    // FIFO handshake decode, alignment test and address arithmetic
    always_comb begin
        fifo_full_s     = (count_q == FULL_CNT);
        // Pixels are discarded while a flush is pending so the stale
        // remainder of the broken frame never mixes with the new one.
        fifo_wr_s       = bus.pix_en & ~fifo_full_s & ~flush_pend_q
                          & (state_q != ST_FLUSH);
        // dreq outside a burst is ignored; inside a burst the controller
        // never pulls more than BURST_LEN words, which were present at REQ.
        fifo_rd_s       = (state_q == ST_XFER) & bus.sdram_wr_dreq;
        frame_aligned_s = (state_q == ST_IDLE) && (count_q == {CNT_W{1'b0}})
                          && (offset_q == {ADDR_W{1'b0}});
        next_offset_s   = offset_q + BURST_STEP;
        if (bank_q) begin
            burst_base_s = BASE_ADDR1;
        end else begin
            burst_base_s = BASE_ADDR0;
        end
    end

    // Next-state logic: FIFO pointers, burst FSM, frame addressing, flags
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        beat_d       = beat_q;
        offset_d     = offset_q;
        bank_d       = bank_q;
        flush_pend_d = flush_pend_q;
        req_d        = req_q;
        addr_d       = addr_q;
        data_d       = data_q;
        frame_done_d = 1'b0;
        rd_bank_d    = rd_bank_q;
        ovf_d        = ovf_q;
        sync_err_d   = sync_err_q;

        // FIFO bookkeeping; a read and a write in the same cycle cancel out
        if (fifo_wr_s) begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (fifo_rd_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            data_d   = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d = rd_ptr_q;
            data_d   = data_q;
        end
        count_d = count_q + CNT_W'(fifo_wr_s) - CNT_W'(fifo_rd_s);

        if (bus.pix_en && fifo_full_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (flush_pend_q) begin
                    state_d = ST_FLUSH;
                end else if (count_q >= BURST_CNT) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    addr_d  = burst_base_s + offset_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.sdram_wr_ack) begin
                    state_d = ST_XFER;
                    req_d   = 1'b0;
                    beat_d  = {BEAT_W{1'b0}};
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_XFER: begin
                if (fifo_rd_s) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                        beat_d  = {BEAT_W{1'b0}};
                        if (next_offset_s == FRAME_END) begin
                            offset_d     = {ADDR_W{1'b0}};
                            frame_done_d = 1'b1;
`ifdef WR_PINGPONG_EN
                            bank_d    = ~bank_q;
                            rd_bank_d = bank_q;
`else
                            bank_d    = 1'b0;
                            rd_bank_d = 1'b0;
`endif
                        end else begin
                            offset_d = next_offset_s;
                        end
                    end else begin
                        beat_d = beat_q + {{(BEAT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_FLUSH: begin
                // Drop the partial frame; the bank is left untouched
                state_d      = ST_IDLE;
                wr_ptr_d     = {PTR_W{1'b0}};
                rd_ptr_d     = {PTR_W{1'b0}};
                count_d      = {CNT_W{1'b0}};
                offset_d     = {ADDR_W{1'b0}};
                flush_pend_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // A frame_start that does not land on a clean frame boundary
        // schedules a flush; it overrides the clear done in ST_FLUSH.
        if (bus.frame_start && !frame_aligned_s) begin
            sync_err_d   = 1'b1;
            flush_pend_d = 1'b1;
        end else begin
            sync_err_d   = sync_err_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            beat_q       <= {BEAT_W{1'b0}};
            offset_q     <= {ADDR_W{1'b0}};
            bank_q       <= 1'b0;
            flush_pend_q <= 1'b0;
            req_q        <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            data_q       <= 16'h0000;
            frame_done_q <= 1'b0;
            rd_bank_q    <= 1'b0;
            ovf_q        <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            beat_q       <= beat_d;
            offset_q     <= offset_d;
            bank_q       <= bank_d;
            flush_pend_q <= flush_pend_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            rd_bank_q    <= rd_bank_d;
            ovf_q        <= ovf_d;
            sync_err_q   <= sync_err_d;
        end
    end

    // Buffer array write port; contents need no reset because the
    // pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (fifo_wr_s) begin
            mem_q[wr_ptr_q] <= bus.pix_data;
        end
    end

    assign bus.sdram_wr_req  = req_q;
    assign bus.sdram_wr_addr = addr_q;
    assign bus.sdram_wr_data = data_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.rd_bank       = rd_bank_q;
    assign bus.fifo_ovf      = ovf_q;
    assign bus.sync_err      = sync_err_q;

endmodule

// File: tb/tb_sdram_wr_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sdram_wr_burst_ctrl
// Scoreboard bench: expected burst addresses and pixel words are queued when
// stimulus is driven; a small SDRAM controller model acks requests, pulls
// words and compares what comes out against the queues.
// Small frame (FRAME_WORDS=128) so that frame wrap and bank switching occur.
// -----------------------------------------------------------------------------
module tb_sdram_wr_burst_ctrl;

    localparam int BURST_LEN   = 64;
    localparam int FIFO_DEPTH  = 512;
    localparam int FRAME_WORDS = 128;
    localparam int ADDR_W      = 22;
    localparam logic [ADDR_W-1:0] BASE0 = 22'h000000;
    localparam logic [ADDR_W-1:0] BASE1 = 22'h080000;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    sdram_wr_burst_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    sdram_wr_burst_ctrl #(
        .BURST_LEN  (BURST_LEN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FRAME_WORDS(FRAME_WORDS),
        .ADDR_W     (ADDR_W),
        .BASE_ADDR0 (BASE0),
        .BASE_ADDR1 (BASE1)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0]       exp_data_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];

    // Reference model of frame addressing
    int m_off     = 0;
    bit m_bank    = 1'b0;
    bit m_rd_bank = 1'b0;

    // Controller model controls/state
    bit ctl_en        = 1'b1;
    bit ctl_abort     = 1'b1;
    bit dreq_every    = 1'b1;
    int beats_left    = 0;
    bit data_due      = 1'b0;
    int frame_done_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic expect_bursts(input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back((m_bank ? BASE1 : BASE0) + ADDR_W'(m_off));
            m_off += BURST_LEN;
            if (m_off == FRAME_WORDS) begin
                m_off = 0;
`ifdef WR_PINGPONG_EN
                m_rd_bank = m_bank;
                m_bank    = ~m_bank;
`endif
            end
        end
    endtask

    task automatic send_words(input int n, input int first, input int n_keep);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.pix_en   = 1'b1;
            bus.pix_data = 16'(first + i);
            if (i < n_keep) exp_data_q.push_back(16'(first + i));
        end
        @(negedge clk);
        bus.pix_en = 1'b0;
    endtask

    task automatic pulse_frame_start();
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int cyc = 0;
        while ((exp_data_q.size() != 0 || exp_addr_q.size() != 0) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        check_val("drain_data", 32'(exp_data_q.size()), 32'd0);
        check_val("drain_addr", 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic apply_reset();
        bus.pix_en      = 1'b0;
        bus.frame_start = 1'b0;
        ctl_abort       = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_req",        32'(bus.sdram_wr_req),  32'd0);
        check_val("rst_addr",       32'(bus.sdram_wr_addr), 32'd0);
        check_val("rst_data",       32'(bus.sdram_wr_data), 32'd0);
        check_val("rst_frame_done", 32'(bus.frame_done),    32'd0);
        check_val("rst_rd_bank",    32'(bus.rd_bank),       32'd0);
        check_val("rst_fifo_ovf",   32'(bus.fifo_ovf),      32'd0);
        check_val("rst_sync_err",   32'(bus.sync_err),      32'd0);
        exp_data_q.delete();
        exp_addr_q.delete();
        m_off          = 0;
        m_bank         = 1'b0;
        m_rd_bank      = 1'b0;
        frame_done_cnt = 0;
        rstn      = 1'b1;
        ctl_abort = 1'b0;
        @(negedge clk);
    endtask

    // SDRAM controller model: acks requests, pulls words, scores output
    initial begin : ctl_model
        logic [15:0]       exp_word;
        logic [ADDR_W-1:0] exp_addr;
        bus.sdram_wr_ack  = 1'b0;
        bus.sdram_wr_dreq = 1'b0;
        forever begin
            @(negedge clk);
            if (data_due) begin
                if (exp_data_q.size() > 0) begin
                    exp_word = exp_data_q.pop_front();
                    check_val("wr_data", 32'(bus.sdram_wr_data), 32'(exp_word));
                end else begin
                    check_val("data_avail", 32'(exp_data_q.size()), 32'd1);
                end
            end
            if (bus.frame_done === 1'b1) frame_done_cnt++;
            if (ctl_abort) begin
                bus.sdram_wr_ack  = 1'b0;
                bus.sdram_wr_dreq = 1'b0;
                beats_left        = 0;
                data_due          = 1'b0;
            end else begin
                if (bus.sdram_wr_ack) begin
                    bus.sdram_wr_ack = 1'b0;
                    beats_left       = BURST_LEN;
                end else if (bus.sdram_wr_req === 1'b1 && ctl_en && beats_left == 0) begin
                    if (exp_addr_q.size() > 0) begin
                        exp_addr = exp_addr_q.pop_front();
                        check_val("burst_addr", 32'(bus.sdram_wr_addr), 32'(exp_addr));
                    end else begin
                        check_val("addr_avail", 32'(exp_addr_q.size()), 32'd1);
                    end
                    bus.sdram_wr_ack = 1'b1;
                end
                if (beats_left > 0 && (dreq_every || $urandom_range(0, 1) == 1)) begin
                    bus.sdram_wr_dreq = 1'b1;
                    beats_left--;
                end else begin
                    bus.sdram_wr_dreq = 1'b0;
                end
                data_due = bus.sdram_wr_dreq;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int fd0;
        rstn            = 1'b0;
        bus.pix_en      = 1'b0;
        bus.pix_data    = 16'h0000;
        bus.frame_start = 1'b0;
        apply_reset();

        // 1: aligned frame_start is harmless; single burst 0..63 at addr 0
        pulse_frame_start();
        @(negedge clk);
        check_val("aligned_sync_err", 32'(bus.sync_err), 32'd0);
        expect_bursts(1);
        send_words(64, 0, 64);
        wait_drain(300);
        check_val("t1_frame_done", 32'(frame_done_cnt), 32'd0);

        // 2: three small frames, two bursts each, bank tracking
        apply_reset();
        for (int f = 0; f < 3; f++) begin
            pulse_frame_start();
            expect_bursts(2);
            send_words(128, 16'h1000 + f * 128, 128);
            wait_drain(400);
            check_val("t2_frame_done", 32'(frame_done_cnt), 32'(f + 1));
            check_val("t2_rd_bank", 32'(bus.rd_bank), 32'(m_rd_bank));
        end
        check_val("t2_sync_err", 32'(bus.sync_err), 32'd0);

        // 3: ack withheld, 600 words -> 512 stored, overflow flagged
        fd0        = frame_done_cnt;
        ctl_en     = 1'b0;
        dreq_every = 1'b0;
        expect_bursts(8);
        send_words(600, 16'h2000, 512);
        check_val("t3_fifo_ovf", 32'(bus.fifo_ovf), 32'd1);
        check_val("t3_req_held", 32'(bus.sdram_wr_req), 32'd1);
        check_val("t3_req_addr", 32'(bus.sdram_wr_addr), 32'(exp_addr_q[0]));
        ctl_en = 1'b1;
        wait_drain(3000);
        check_val("t3_frames", 32'(frame_done_cnt - fd0), 32'd4);
        dreq_every = 1'b1;

        // 4: misaligned frame_start mid-burst -> burst completes, flush, restart at base+0
        fd0    = frame_done_cnt;
        ctl_en = 1'b0;
        expect_bursts(1);
        send_words(100, 16'h4000, 64);
        pulse_frame_start();
        @(negedge clk);
        check_val("t4_sync_err", 32'(bus.sync_err), 32'd1);
        send_words(10, 16'h5000, 0);
        ctl_en = 1'b1;
        wait_drain(400);
        m_off = 0;
        expect_bursts(1);
        send_words(64, 16'h6000, 64);
        wait_drain(400);
        check_val("t4_frames", 32'(frame_done_cnt - fd0), 32'd0);

        // 5: pixels keep arriving while bursts drain every cycle
        fd0 = frame_done_cnt;
        expect_bursts(3);
        send_words(192, 16'h7000, 192);
        wait_drain(600);
        check_val("t5_frames", 32'(frame_done_cnt - fd0), 32'd2);

        // 6: reset in the middle of a transfer, then clean restart at 0
        expect_bursts(1);
        send_words(64, 16'h8000, 64);
        for (int c = 0; c < 300 && exp_data_q.size() > 32; c++) @(negedge clk);
        check_val("t6_mid_xfer", 32'(exp_data_q.size() <= 32), 32'd1);
        apply_reset();
        expect_bursts(1);
        send_words(64, 16'h9000, 64);
        wait_drain(300);
        check_val("t6_sync_err", 32'(bus.sync_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
